viterbi_channel_model: RTL

VITERBI_CHANNEL_MODEL -- requirements
Module: viterbi_channel_model

---
 rtl/viterbi_channel_model.sv | 129 ++++++++++++
 1 files changed

// File: rtl/viterbi_channel_model.sv
// Channel error injector for encoder symbols: pass, periodic, random and burst corruption with flip statistics.
// Latency 1 cycle; no backpressure, every valid_i word is accepted and appears on valid_o the next cycle.
module viterbi_channel_model #(
  parameter int W  = 2,
  parameter int LW = 16,
  parameter int CW = 16,
  parameter logic [LW-1:0] SEED = 'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [W-1:0]  sym_i,
  input  logic [1:0]    mode_i,
  input  logic [LW-1:0] thresh_i,
  input  logic [7:0]    period_i,
  input  logic [3:0]    burst_len_i,
  input  logic [W-1:0]  mask_i,
  input  logic [LW-1:0] seed_i,
  input  logic          load_seed_i,
  input  logic          clr_cnt_i,
  output logic          valid_o,
  output logic [W-1:0]  sym_o,
  output logic [W-1:0]  err_o,
  output logic [CW-1:0] bit_err_ct_o,
  output logic [CW-1:0] word_ct_o,
  output logic          sat_o
);

  localparam logic [1:0] MODE_PER   = 2'd1;
  localparam logic [1:0] MODE_RAND  = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [LW-1:0] TAPS = LW'(16'hB400);

  logic [LW-1:0] lfsr, lfsr_nxt;
  logic [7:0]    pcnt, pcnt_eff, pcnt_nxt;
  logic [0:0]    state, state_eff, state_nxt;
  logic [3:0]    remaining, rem_nxt;
  logic [1:0]    mode_q;
  logic          inj, rand_hit;
  logic [W-1:0]  err_nxt;
  logic [CW:0]   pop;
  logic [CW-1:0] wc_base, bc_base;
  logic [CW:0]   wc_sum, bc_sum;
  logic          sat_base;

  // Injection decision uses the pre-advance LFSR and the mode of this very word.
  always_comb begin
    pcnt_eff  = (mode_i == MODE_PER && mode_q != MODE_PER) ? 8'd0 : pcnt;
    state_eff = (mode_i == MODE_BURST) ? state : ST_IDLE;
    rand_hit  = (lfsr < thresh_i);
    inj       = 1'b0;
    pcnt_nxt  = pcnt_eff;
    state_nxt = state_eff;
    rem_nxt   = remaining;
    if (valid_i) begin
      case (mode_i)
        MODE_PER: begin
          if (pcnt_eff == period_i) begin
            inj      = 1'b1;
            pcnt_nxt = 8'd0;
          end else begin
            pcnt_nxt = pcnt_eff + 8'd1;
          end
        end
        MODE_RAND: inj = rand_hit;
        MODE_BURST: begin
          if (state_eff == ST_BURST) begin
            inj     = 1'b1;
            rem_nxt = remaining - 4'd1;
            if (remaining == 4'd1) state_nxt = ST_IDLE;
          end else if (rand_hit) begin
            inj     = 1'b1;
            rem_nxt = burst_len_i;
            if (burst_len_i != 4'd0) state_nxt = ST_BURST;
          end
        end
        default: inj = 1'b0;
      endcase
    end
    err_nxt = inj ? mask_i : '0;

    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + (CW+1)'(err_nxt[i]);

    if (load_seed_i)  lfsr_nxt = (seed_i == '0) ? LW'(1) : seed_i;
    else if (valid_i) lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    else              lfsr_nxt = lfsr;

    // A coincident clear leaves only this word's contribution in the counters.
    wc_base  = clr_cnt_i ? '0 : word_ct_o;
    bc_base  = clr_cnt_i ? '0 : bit_err_ct_o;
    sat_base = clr_cnt_i ? 1'b0 : sat_o;
    wc_sum   = {1'b0, wc_base} + (CW+1)'(valid_i);
    bc_sum   = {1'b0, bc_base} + pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr         <= SEED;
      pcnt         <= '0;
      state        <= ST_IDLE;
      remaining    <= '0;
      mode_q       <= '0;
      valid_o      <= 1'b0;
      sym_o        <= '0;
      err_o        <= '0;
      word_ct_o    <= '0;
      bit_err_ct_o <= '0;
      sat_o        <= 1'b0;
    end else begin
      lfsr         <= lfsr_nxt;
      pcnt         <= pcnt_nxt;
      state        <= state_nxt;
      remaining    <= rem_nxt;
      mode_q       <= mode_i;
      valid_o      <= valid_i;
      err_o        <= err_nxt;
      if (valid_i) sym_o <= sym_i ^ err_nxt;
      word_ct_o    <= wc_sum[CW] ? '1 : wc_sum[CW-1:0];
      bit_err_ct_o <= bc_sum[CW] ? '1 : bc_sum[CW-1:0];
      sat_o        <= sat_base | wc_sum[CW] | bc_sum[CW];
    end
  end

endmodule
